fazyrv_seq_alu: RTL and testbench
=================================

FAZYRV_SEQ_ALU -- requirements
Module: fazyrv_seq_alu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the full operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNKSIZE, default 2, meaning the bits processed per cycle; legal values are 1, 2, 4 and 8, and CHUNKSIZE SHALL divide XLEN.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, rising-edge sensitive.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port op_i, input, 3 bits: 000 ADD, 001 SUB, 010 XOR, 011 OR, 100 AND, 101 SLT, 110 SLTU, 111 EQ.
REQ-007 The block SHALL have ports a_i and b_i, input, XLEN bits each: operands, sampled only on accept.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high while an operation is in flight.
REQ-009 The block SHALL have port done_o, output, 1 bit: one-cycle pulse marking that res_o and cmp_o are valid.
REQ-010 The block SHALL have port res_o, output, XLEN bits: the result.
REQ-011 The block SHALL have port cmp_o, output, 1 bit: the comparison result.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and DONE, with N = XLEN/CHUNKSIZE.
REQ-013 start_i SHALL be accepted only when the state is IDLE or DONE; on accept, a_i, b_i and op_i SHALL be latched, the chunk counter set to 0, and the state set to RUN.
REQ-014 start_i while in RUN SHALL be ignored: no relatch, no counter change, no effect on the current operation.
REQ-015 In RUN, the block SHALL process one CHUNKSIZE-bit chunk per cycle, LSB chunk first, using chunk counter k = 0..N-1, and shift the result chunk into a result register.
REQ-016 Add/subtract SHALL use a registered carry between chunks; the carry-in for chunk 0 SHALL be 0 for ADD and 1 for SUB, with b inverted for SUB, SLT, SLTU and EQ.
REQ-017 The chunk counter SHALL wrap to 0 after chunk N-1, and the state SHALL move RUN->DONE at that edge.
REQ-018 DONE SHALL last exactly one cycle; with no accept it SHALL move to IDLE; an accept in DONE SHALL move it directly to RUN, giving a back-to-back throughput of one operation per N+1 cycles.
REQ-019 done_o SHALL be high only in DONE, i.e. exactly N+1 cycles after the accept cycle (17 cycles for XLEN=32, CHUNKSIZE=2).
REQ-020 busy_o SHALL be high only in RUN.
REQ-021 res_o and cmp_o SHALL be valid in DONE and SHALL hold their values through IDLE until the next DONE; during RUN they are don't-care.
REQ-022 ADD and SUB SHALL compute the sum/difference modulo 2^XLEN, with cmp_o = 0.
REQ-023 XOR, OR and AND SHALL compute the bitwise result, with cmp_o = 0.
REQ-024 SLT/SLTU SHALL set cmp_o = (a < b), signed for SLT and unsigned for SLTU, decided by a running lo/gr comparison that is overwritten by each more-significant chunk; the MSB of a and b SHALL be inverted in the final chunk for SLT.
REQ-025 EQ SHALL set cmp_o = (a == b), accumulated as the AND over all chunks.
REQ-026 For SLT, SLTU and EQ, res_o SHALL be {XLEN-1 zeros, cmp_o}.
REQ-027 The running carry and compare state SHALL be re-initialised on every accept so that no state leaks between operations.

Reset
REQ-028 When rst_i is high at a rising edge, the block SHALL set state to IDLE, the chunk counter to 0, busy_o to 0, done_o to 0, res_o to 0, cmp_o to 0 and the carry to 0.
REQ-029 Reset SHALL take priority over start_i in the same cycle.
REQ-030 Reset mid-RUN SHALL abort the operation, with no done_o pulse for it.
REQ-031 The first accept after reset release SHALL behave identically to an accept from power-up.

Verification
REQ-032 ADD a=0xFFFFFFFF, b=0x00000001 -> done_o after 17 cycles, res_o=0x00000000, cmp_o=0.
REQ-033 SUB a=0x00000000, b=0x00000001 -> res_o=0xFFFFFFFF; then SLT with the same a=0xFFFFFFFF, b=1 -> cmp_o=1, res_o=0x00000001; SLTU with the same operands -> cmp_o=0, res_o=0.
REQ-034 EQ a=b=0x80000001 -> cmp_o=1; EQ a=0x80000001, b=0x00000001 -> cmp_o=0, which checks the MSB chunk.
REQ-035 start_i held high continuously with distinct operands -> each operation accepted only in DONE, done_o pulses every 17 cycles, and start_i pulses during RUN have no effect.
REQ-036 rst_i asserted at chunk 5 of an ADD -> next cycle busy_o=0, done_o stays 0 and res_o=0; a subsequent AND 0xF0F0F0F0 & 0xFF00FF00 -> res_o=0xF000F000.
REQ-037 Scenarios REQ-032 to REQ-036 SHALL be repeated with CHUNKSIZE=1 (done after 33 cycles), CHUNKSIZE=4 (9 cycles) and CHUNKSIZE=8 (5 cycles), giving identical results.

Source files
------------

// File: rtl/fazyrv_seq_alu.sv
// Chunk-serial ALU: processes CHUNKSIZE bits per cycle, LSB chunk first,
// producing an XLEN-bit result and a comparison flag after XLEN/CHUNKSIZE cycles.
module fazyrv_seq_alu #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned CHUNKSIZE = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [XLEN-1:0]   res_o,
   output logic              cmp_o
);

   localparam int unsigned N  = XLEN / CHUNKSIZE;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_XOR  = 3'b010,
      OP_OR   = 3'b011,
      OP_AND  = 3'b100,
      OP_SLT  = 3'b101,
      OP_SLTU = 3'b110,
      OP_EQ   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e               state_q, state_d;
   op_e                  op_q;
   logic [XLEN-1:0]      a_q, b_q, res_q;
   logic [CW-1:0]        cnt_q;
   logic                 carry_q, lo_q, eq_q, cmp_q;

   logic                 accept, last, sub_like, is_cmp;
   logic [CHUNKSIZE-1:0] a_c, b_c, b_eff, r_c;
   logic [CHUNKSIZE:0]   sum;
   logic                 lo_d, eq_d, cmp_fin;
   logic [XLEN-1:0]      res_nxt;

   assign accept = start_i && (state_q != S_RUN);
   assign last   = (cnt_q == CW'(N - 1));
   assign res_o  = res_q;
   assign cmp_o  = cmp_q;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and status outputs
   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         S_IDLE: if (start_i) state_d = S_RUN;
         S_RUN: begin
            busy_o = 1'b1;
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = start_i ? S_RUN : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Per-chunk arithmetic, logic and running comparison
   always_comb begin
      sub_like = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU) || (op_q == OP_EQ);
      is_cmp   = (op_q == OP_SLT) || (op_q == OP_SLTU) || (op_q == OP_EQ);
      a_c      = a_q[CHUNKSIZE-1:0];
      b_c      = b_q[CHUNKSIZE-1:0];
      // Flipping both sign bits turns the signed compare into an unsigned one.
      if (last && (op_q == OP_SLT)) begin
         a_c[CHUNKSIZE-1] = ~a_c[CHUNKSIZE-1];
         b_c[CHUNKSIZE-1] = ~b_c[CHUNKSIZE-1];
      end
      b_eff = sub_like ? ~b_c : b_c;
      sum   = {1'b0, a_c} + {1'b0, b_eff} + {{CHUNKSIZE{1'b0}}, carry_q};
      // A more-significant chunk that differs overrides the verdict so far.
      if (a_c < b_c)      lo_d = 1'b1;
      else if (a_c > b_c) lo_d = 1'b0;
      else                lo_d = lo_q;
      eq_d = eq_q && (a_c == b_c);
      case (op_q)
         OP_ADD, OP_SUB: r_c = sum[CHUNKSIZE-1:0];
         OP_XOR:         r_c = a_c ^ b_c;
         OP_OR:          r_c = a_c | b_c;
         OP_AND:         r_c = a_c & b_c;
         default:        r_c = '0;
      endcase
      if ((op_q == OP_SLT) || (op_q == OP_SLTU)) cmp_fin = lo_d;
      else if (op_q == OP_EQ)                    cmp_fin = eq_d;
      else                                       cmp_fin = 1'b0;
   end

   if (N > 1) begin : g_shift
      assign res_nxt = {r_c, res_q[XLEN-1:CHUNKSIZE]};
   end else begin : g_noshift
      assign res_nxt = r_c;
   end

   // Operand latch, chunk counter, carry/compare state and result shift register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         lo_q    <= 1'b0;
         eq_q    <= 1'b0;
         res_q   <= '0;
         cmp_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= a_i;
         b_q     <= b_i;
         op_q    <= op_e'(op_i);
         cnt_q   <= '0;
         carry_q <= (op_i != OP_ADD);
         lo_q    <= 1'b0;
         eq_q    <= 1'b1;
      end else if (state_q == S_RUN) begin
         a_q     <= a_q >> CHUNKSIZE;
         b_q     <= b_q >> CHUNKSIZE;
         carry_q <= sum[CHUNKSIZE];
         lo_q    <= lo_d;
         eq_q    <= eq_d;
         cnt_q   <= last ? '0 : cnt_q + 1'b1;
         if (last) begin
            cmp_q <= cmp_fin;
            res_q <= is_cmp ? {{(XLEN-1){1'b0}}, cmp_fin} : res_nxt;
         end else begin
            res_q <= res_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fazyrv_seq_alu.sv
// Bench for fazyrv_seq_alu: four instances (CHUNKSIZE 1,2,4,8) share stimulus and
// are compared every cycle against an operation-level reference model.
module tb_fazyrv_seq_alu;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [2:0]  op;
   logic [31:0] a, b;

   logic        busy [4];
   logic        done [4];
   logic [31:0] res  [4];
   logic        cmp  [4];

   // Reference model state per instance
   int          m_rem  [4];
   logic        m_done [4];
   logic [31:0] m_res  [4];
   logic        m_cmp  [4];
   logic [2:0]  l_op   [4];
   logic [31:0] l_a    [4];
   logic [31:0] l_b    [4];

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      fazyrv_seq_alu #(.XLEN(32), .CHUNKSIZE(1 << g)) u_dut (
         .clk_i  (clk),
         .rst_i  (rst),
         .start_i(start),
         .op_i   (op),
         .a_i    (a),
         .b_i    (b),
         .busy_o (busy[g]),
         .done_o (done[g]),
         .res_o  (res[g]),
         .cmp_o  (cmp[g])
      );
   end

   // Returns {cmp, res}
   function automatic logic [32:0] ref_alu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic c;
      case (o)
         3'd0: return {1'b0, x + y};
         3'd1: return {1'b0, x - y};
         3'd2: return {1'b0, x ^ y};
         3'd3: return {1'b0, x | y};
         3'd4: return {1'b0, x & y};
         3'd5: begin c = ($signed(x) < $signed(y)); return {c, 31'd0, c}; end
         3'd6: begin c = (x < y);                   return {c, 31'd0, c}; end
         default: begin c = (x == y);               return {c, 31'd0, c}; end
      endcase
   endfunction

   // One clock edge: advance the model with the inputs seen at the edge, then settle.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            m_rem[i] = 0; m_done[i] = 1'b0; m_res[i] = '0; m_cmp[i] = 1'b0;
         end else if (m_rem[i] != 0) begin
            m_rem[i]--;
            m_done[i] = 1'b0;
            if (m_rem[i] == 0) begin
               m_done[i] = 1'b1;
               {m_cmp[i], m_res[i]} = ref_alu(l_op[i], l_a[i], l_b[i]);
            end
         end else begin
            m_done[i] = 1'b0;
            if (start) begin
               m_rem[i] = 32 >> i;
               l_op[i] = op; l_a[i] = a; l_b[i] = b;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic [34:0] exp_v, obs_v;
      rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'h1234_5678; b = 32'h1;
      for (int t = 0; t < 3; t++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            exp_v = {1'b0, 1'b0, 32'h0, 1'b0};
            obs_v = {busy[i], done[i], res[i], cmp[i]};
            tests_run++;
            if (obs_v !== exp_v) begin
               fails++;
               $display("FAIL reset cs=%0d: busy/done/res/cmp got %b/%b/%h/%b want 0/0/00000000/0",
                        1 << i, obs_v[34], obs_v[33], obs_v[32:1], obs_v[0]);
            end
         end
      end
      rst = 1'b0; start = 1'b0;
   endtask

   task automatic test_directed();
      logic [34:0] exp_v, obs_v;
      logic [2:0]  t_op  [9] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7, 3'd7, 3'd4, 3'd5, 3'd6};
      logic [31:0] t_a   [9] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001,
                                 32'h80000001, 32'hF0F0F0F0, 32'h7FFFFFFF, 32'h7FFFFFFF};
      logic [31:0] t_b   [9] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h80000001,
                                 32'h1, 32'hFF00FF00, 32'h80000000, 32'h80000000};
      logic [31:0] t_res [9] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 32'h0, 32'hF000F000, 32'h0, 32'h1};
      logic        t_cmp [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int n = 0; n < 9; n++) begin
         start = 1'b1; op = t_op[n]; a = t_a[n]; b = t_b[n];
         tick();
         start = 1'b0;
         for (int j = 1; j <= 36; j++) begin
            // operands change after accept and must be ignored
            op = 3'($urandom); a = $urandom; b = $urandom;
            tick();
            for (int i = 0; i < 4; i++) begin
               exp_v = {m_rem[i] != 0, m_done[i], m_res[i], m_cmp[i]};
               obs_v = {busy[i], done[i], res[i], cmp[i]};
               if (m_rem[i] != 0) begin exp_v[32:0] = '0; obs_v[32:0] = '0; end
               tests_run++;
               if (obs_v !== exp_v) begin
                  fails++;
                  $display("FAIL directed#%0d cs=%0d cyc=%0d: busy/done/res/cmp got %b/%b/%h/%b want %b/%b/%h/%b",
                           n, 1 << i, j, obs_v[34], obs_v[33], obs_v[32:1], obs_v[0],
                           exp_v[34], exp_v[33], exp_v[32:1], exp_v[0]);
               end
               if (j == (32 >> i)) begin
                  tests_run++;
                  if (done[i] !== 1'b1 || res[i] !== t_res[n] || cmp[i] !== t_cmp[n]) begin
                     fails++;
                     $display("FAIL directed_const#%0d cs=%0d: done/res/cmp got %b/%h/%b want 1/%h/%b",
                              n, 1 << i, done[i], res[i], cmp[i], t_res[n], t_cmp[n]);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [34:0] exp_v, obs_v;
      int pulses;
      pulses = 0;
      start = 1'b1;
      for (int j = 0; j < 170; j++) begin
         if (j >= 130) start = 1'b0;
         op = 3'($urandom); a = $urandom; b = $urandom;
         tick();
         if (done[1] === 1'b1) pulses++;
         for (int i = 0; i < 4; i++) begin
            exp_v = {m_rem[i] != 0, m_done[i], m_res[i], m_cmp[i]};
            obs_v = {busy[i], done[i], res[i], cmp[i]};
            if (m_rem[i] != 0) begin exp_v[32:0] = '0; obs_v[32:0] = '0; end
            tests_run++;
            if (obs_v !== exp_v) begin
               fails++;
               $display("FAIL back_to_back cs=%0d cyc=%0d: busy/done/res/cmp got %b/%b/%h/%b want %b/%b/%h/%b",
                        1 << i, j, obs_v[34], obs_v[33], obs_v[32:1], obs_v[0],
                        exp_v[34], exp_v[33], exp_v[32:1], exp_v[0]);
            end
         end
      end
      // start high over edges 0..129 with one op per 17 cycles: accepts at 0,17,..,119 -> 8 done pulses
      tests_run++;
      if (pulses != 8) begin
         fails++;
         $display("FAIL back_to_back_pulses cs=2: got %0d want 8", pulses);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [34:0] exp_v, obs_v;
      start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
      tick();
      start = 1'b0;
      for (int j = 0; j < 5; j++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (busy[i] !== 1'b0 || done[i] !== 1'b0 || res[i] !== 32'h0 || cmp[i] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run cs=%0d: busy/done/res/cmp got %b/%b/%h/%b want 0/0/00000000/0",
                     1 << i, busy[i], done[i], res[i], cmp[i]);
         end
      end
      for (int j = 0; j < 40; j++) begin
         start = (j == 3); op = 3'd4; a = 32'hF0F0F0F0; b = 32'hFF00FF00;
         tick();
         for (int i = 0; i < 4; i++) begin
            exp_v = {m_rem[i] != 0, m_done[i], m_res[i], m_cmp[i]};
            obs_v = {busy[i], done[i], res[i], cmp[i]};
            if (m_rem[i] != 0) begin exp_v[32:0] = '0; obs_v[32:0] = '0; end
            tests_run++;
            if (obs_v !== exp_v) begin
               fails++;
               $display("FAIL after_reset cs=%0d cyc=%0d: busy/done/res/cmp got %b/%b/%h/%b want %b/%b/%h/%b",
                        1 << i, j, obs_v[34], obs_v[33], obs_v[32:1], obs_v[0],
                        exp_v[34], exp_v[33], exp_v[32:1], exp_v[0]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (res[i] !== 32'hF000F000 || cmp[i] !== 1'b0) begin
            fails++;
            $display("FAIL and_after_reset cs=%0d: res/cmp got %h/%b want f000f000/0", 1 << i, res[i], cmp[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [34:0] exp_v, obs_v;
      for (int j = 0; j < 900; j++) begin
         rst   = ($urandom_range(0, 149) == 0);
         start = ($urandom_range(0, 2) == 0);
         op    = 3'($urandom);
         a     = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ (32'h1 << $urandom_range(0, 31));
            default: b = $urandom;
         endcase
         tick();
         for (int i = 0; i < 4; i++) begin
            exp_v = {m_rem[i] != 0, m_done[i], m_res[i], m_cmp[i]};
            obs_v = {busy[i], done[i], res[i], cmp[i]};
            if (m_rem[i] != 0) begin exp_v[32:0] = '0; obs_v[32:0] = '0; end
            tests_run++;
            if (obs_v !== exp_v) begin
               fails++;
               $display("FAIL random cs=%0d cyc=%0d: busy/done/res/cmp got %b/%b/%h/%b want %b/%b/%h/%b",
                        1 << i, j, obs_v[34], obs_v[33], obs_v[32:1], obs_v[0],
                        exp_v[34], exp_v[33], exp_v[32:1], exp_v[0]);
            end
         end
      end
      rst = 1'b0; start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      for (int i = 0; i < 4; i++) begin
         m_rem[i] = 0; m_done[i] = 1'b0; m_res[i] = '0; m_cmp[i] = 1'b0;
         l_op[i] = '0; l_a[i] = '0; l_b[i] = '0;
      end
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
